// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers for the EX stage.
// One radix-2 step per CALC cycle; busy stalls the pipeline, done pulses for one cycle.
module muldiv_hilo #(
  parameter int WIDTH              = 32,
  parameter int ALU_CONTROL_LENGTH = 5,
  parameter logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MULT  = 5'd24,
  parameter logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MULTU = 5'd25,
  parameter logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_DIVU  = 5'd26,
  parameter logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MTHI  = 5'd27,
  parameter logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MTLO  = 5'd28,
  parameter logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MFHI  = 5'd29,
  parameter logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MFLO  = 5'd30
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          cancel,
  input  logic [ALU_CONTROL_LENGTH-1:0] alu_control,
  input  logic [WIDTH-1:0]              src_a,
  input  logic [WIDTH-1:0]              src_b,
  output logic                          busy,
  output logic                          done,
  output logic [WIDTH-1:0]              hi,
  output logic [WIDTH-1:0]              lo,
  output logic [WIDTH-1:0]              result
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [5:0] LAST_CNT = 6'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [5:0]         r_cnt;
  logic               r_div;
  logic               r_neg;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;

  logic [1:0]         w_state_nxt;
  logic [5:0]         w_cnt_nxt;
  logic               w_div_nxt;
  logic               w_neg_nxt;
  logic [WIDTH-1:0]   w_a_nxt;
  logic [WIDTH-1:0]   w_b_nxt;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0]   w_hi_nxt;
  logic [WIDTH-1:0]   w_lo_nxt;

  logic               w_accept;
  logic               w_signed;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_add;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quo;

  assign w_accept = (r_state != S_CALC) && start && !cancel;
  assign w_signed = (alu_control == ALU_CONTROL_MULT);

  // Magnitudes for the signed multiply; the most negative value maps to unsigned 2^(WIDTH-1).
  assign w_abs_a = (w_signed && src_a[WIDTH-1]) ? ({WIDTH{1'b0}} - src_a) : src_a;
  assign w_abs_b = (w_signed && src_b[WIDTH-1]) ? ({WIDTH{1'b0}} - src_b) : src_b;

  // Shift-add step: the upper half of the accumulator absorbs the multiplicand, then shifts right.
  assign w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_prod     = {w_add, r_acc[WIDTH-1:1]};
  assign w_prod_fix = r_neg ? ({(2*WIDTH){1'b0}} - w_prod) : w_prod;

  // Restoring step: partial remainder lives in the accumulator's upper half, dividend/quotient in r_b.
  assign w_shift = {r_acc[2*WIDTH-1:WIDTH], r_b[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_a};
  assign w_qbit  = ~w_trial[WIDTH];
  assign w_rem   = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo   = {r_b[WIDTH-2:0], w_qbit};

  // Next-state and datapath update logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div;
    w_neg_nxt   = r_neg;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_acc_nxt   = r_acc;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_state_nxt = S_IDLE;
        if (w_accept) begin
          case (alu_control)
            ALU_CONTROL_MULT, ALU_CONTROL_MULTU: begin
              w_state_nxt = S_CALC;
              w_cnt_nxt   = 6'd0;
              w_div_nxt   = 1'b0;
              w_neg_nxt   = w_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
              w_a_nxt     = w_abs_a;
              w_b_nxt     = w_abs_b;
              w_acc_nxt   = {(2*WIDTH){1'b0}};
            end
            ALU_CONTROL_DIVU: begin
              w_state_nxt = S_CALC;
              w_cnt_nxt   = 6'd0;
              w_div_nxt   = 1'b1;
              w_neg_nxt   = 1'b0;
              w_a_nxt     = src_b;
              w_b_nxt     = src_a;
              w_acc_nxt   = {(2*WIDTH){1'b0}};
            end
            ALU_CONTROL_MTHI: w_hi_nxt = src_a;
            ALU_CONTROL_MTLO: w_lo_nxt = src_a;
            default:          w_state_nxt = S_IDLE;
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (cancel) begin
          w_state_nxt = S_IDLE;
        end else begin
          if (r_div) begin
            w_acc_nxt = {w_rem, {WIDTH{1'b0}}};
            w_b_nxt   = w_quo;
          end else begin
            w_acc_nxt = w_prod;
            w_b_nxt   = {1'b0, r_b[WIDTH-1:1]};
          end
          if (r_cnt == LAST_CNT) begin
            w_state_nxt = S_DONE;
            if (r_div) begin
              w_hi_nxt = w_rem;
              w_lo_nxt = w_quo;
            end else begin
              w_hi_nxt = w_prod_fix[2*WIDTH-1:WIDTH];
              w_lo_nxt = w_prod_fix[WIDTH-1:0];
            end
          end else begin
            w_cnt_nxt = r_cnt + 6'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
      r_div   <= 1'b0;
      r_neg   <= 1'b0;
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_acc   <= {(2*WIDTH){1'b0}};
      r_hi    <= {WIDTH{1'b0}};
      r_lo    <= {WIDTH{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_div   <= w_div_nxt;
      r_neg   <= w_neg_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_acc   <= w_acc_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_busy  <= (w_state_nxt == S_CALC);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Move-from read port; no forwarding from an in-flight operation.
  always_comb begin
    case (alu_control)
      ALU_CONTROL_MFHI: result = r_hi;
      ALU_CONTROL_MFLO: result = r_lo;
      default:          result = {WIDTH{1'b0}};
    endcase
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
